// File: rtl/mul_div_unit.sv
// -----------------------------------------------------------------------------
// mul_div_unit
// Multi-cycle integer multiply / divide unit placed beside the ALU.
// Multiply is shift-add and divide is restoring, both one bit per cycle.
// The decoder pulses start, stalls until done, then writes result_lo/hi back.
//
// Configuration macro: MDU_SIGNED_EN
//   defined   -> adds the signed_op port and a SIGN fix-up state
//                (+1 cycle of latency on every operation except divide by zero)
//   undefined -> unsigned only
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   asynchronous reset, active low
//   start      in   request, sampled only when the unit is free (IDLE or DONE)
//   op         in   0 = MUL, 1 = DIV, captured with start
//   signed_op  in   two's-complement mode (MDU_SIGNED_EN builds only)
//   a          in   multiplicand / dividend
//   b          in   multiplier / divisor
//   busy       out  high from the accepting edge until the edge raising done
//   done       out  one-cycle completion pulse
//   result_lo  out  product low half / quotient
//   result_hi  out  product high half / remainder
//   flags      out  {ov, dz, zf}, updated with done
// -----------------------------------------------------------------------------
module mul_div_unit #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             op,
`ifdef MDU_SIGNED_EN
   input  logic             signed_op,
`endif
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result_lo,
   output logic [WIDTH-1:0] result_hi,
   output logic [2:0]       flags
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
`ifdef MDU_SIGNED_EN
      S_SIGN = 2'd2,
`endif
      S_DONE = 2'd3
   } state_t;

   state_t           state_q;
   logic [CW-1:0]    cnt_q;
   logic             op_q;
   logic             dz_q;
   logic [WIDTH-1:0] hi_q;      // MUL: product high half, DIV: remainder
   logic [WIDTH-1:0] lo_q;      // MUL: multiplier/product low, DIV: dividend/quotient
   logic [WIDTH-1:0] opnd_q;    // MUL: multiplicand, DIV: divisor
   logic             busy_q;
   logic             done_q;
   logic [WIDTH-1:0] res_lo_q;
   logic [WIDTH-1:0] res_hi_q;
   logic [2:0]       flags_q;
`ifdef MDU_SIGNED_EN
   logic             sgn_q;
   logic             neg_res_q;
   logic             neg_rem_q;
   logic             ovmin_q;
   logic             neg_a_d;
   logic             neg_b_d;
   logic [2*WIDTH-1:0] prod_d;
`endif

   logic [WIDTH-1:0] mag_a_d;
   logic [WIDTH-1:0] mag_b_d;
   logic [WIDTH:0]   mul_sum_d;
   logic [WIDTH:0]   div_sh_d;
   logic             div_ge_d;
   logic [WIDTH-1:0] hi_step_d;
   logic [WIDTH-1:0] lo_step_d;
   logic [WIDTH-1:0] fin_hi_d;
   logic [WIDTH-1:0] fin_lo_d;
   logic             fin_ov_d;
   logic             fin_zf_d;

   // Operand magnitudes presented at accept time
   always_comb begin
`ifdef MDU_SIGNED_EN
      neg_a_d = signed_op & a[WIDTH-1];
      neg_b_d = signed_op & b[WIDTH-1];
      if (neg_a_d) begin
         mag_a_d = {WIDTH{1'b0}} - a;
      end else begin
         mag_a_d = a;
      end
      if (neg_b_d) begin
         mag_b_d = {WIDTH{1'b0}} - b;
      end else begin
         mag_b_d = b;
      end
`else
      mag_a_d = a;
      mag_b_d = b;
`endif
   end

   // One iteration of shift-add multiply or restoring divide
   always_comb begin
      if (lo_q[0]) begin
         mul_sum_d = {1'b0, hi_q} + {1'b0, opnd_q};
      end else begin
         mul_sum_d = {1'b0, hi_q};
      end
      // Shifted remainder needs WIDTH+1 bits: it can reach 2*divisor-1
      div_sh_d = {hi_q, lo_q[WIDTH-1]};
      div_ge_d = (div_sh_d >= {1'b0, opnd_q});
      if (op_q == 1'b0) begin
         hi_step_d = mul_sum_d[WIDTH:1];
         lo_step_d = {mul_sum_d[0], lo_q[WIDTH-1:1]};
      end else if (div_ge_d) begin
         hi_step_d = WIDTH'(div_sh_d - {1'b0, opnd_q});
         lo_step_d = {lo_q[WIDTH-2:0], 1'b1};
      end else begin
         hi_step_d = div_sh_d[WIDTH-1:0];
         lo_step_d = {lo_q[WIDTH-2:0], 1'b0};
      end
   end

   // Final result and flags: unsigned results come straight from the last
   // iteration, signed results are fixed up from the held magnitudes in SIGN
   always_comb begin
`ifdef MDU_SIGNED_EN
      prod_d = {hi_q, lo_q};
      if (op_q == 1'b0) begin
         if (neg_res_q) begin
            prod_d = {(2*WIDTH){1'b0}} - {hi_q, lo_q};
         end else begin
            prod_d = {hi_q, lo_q};
         end
         fin_hi_d = prod_d[2*WIDTH-1:WIDTH];
         fin_lo_d = prod_d[WIDTH-1:0];
         if (sgn_q) begin
            fin_ov_d = (fin_hi_d != {WIDTH{fin_lo_d[WIDTH-1]}});
         end else begin
            fin_ov_d = (fin_hi_d != {WIDTH{1'b0}});
         end
      end else begin
         if (neg_res_q) begin
            fin_lo_d = {WIDTH{1'b0}} - lo_q;
         end else begin
            fin_lo_d = lo_q;
         end
         // Remainder takes the dividend's sign (truncation toward zero)
         if (neg_rem_q) begin
            fin_hi_d = {WIDTH{1'b0}} - hi_q;
         end else begin
            fin_hi_d = hi_q;
         end
         fin_ov_d = ovmin_q;
      end
`else
      fin_hi_d = hi_step_d;
      fin_lo_d = lo_step_d;
      if (op_q == 1'b0) begin
         fin_ov_d = (hi_step_d != {WIDTH{1'b0}});
      end else begin
         fin_ov_d = 1'b0;
      end
`endif
      fin_zf_d = (fin_hi_d == {WIDTH{1'b0}}) && (fin_lo_d == {WIDTH{1'b0}});
   end

   // Control FSM, datapath registers and registered outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= S_IDLE;
         cnt_q     <= {CW{1'b0}};
         op_q      <= 1'b0;
         dz_q      <= 1'b0;
         hi_q      <= {WIDTH{1'b0}};
         lo_q      <= {WIDTH{1'b0}};
         opnd_q    <= {WIDTH{1'b0}};
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         res_lo_q  <= {WIDTH{1'b0}};
         res_hi_q  <= {WIDTH{1'b0}};
         flags_q   <= 3'b000;
`ifdef MDU_SIGNED_EN
         sgn_q     <= 1'b0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         ovmin_q   <= 1'b0;
`endif
      end else begin
         done_q <= 1'b0;
         case (state_q)
            // The done cycle accepts a new start just like IDLE
            S_IDLE, S_DONE: begin
               if (start) begin
                  busy_q  <= 1'b1;
                  op_q    <= op;
                  cnt_q   <= CW'(WIDTH);
                  state_q <= S_RUN;
`ifdef MDU_SIGNED_EN
                  sgn_q     <= signed_op;
                  neg_res_q <= neg_a_d ^ neg_b_d;
                  neg_rem_q <= neg_a_d;
                  ovmin_q   <= signed_op & op
                               & (a == {1'b1, {(WIDTH-1){1'b0}}})
                               & (b == {WIDTH{1'b1}});
`endif
                  if (op && (b == {WIDTH{1'b0}})) begin
                     // Divide by zero: final values loaded now, RUN only
                     // spends one cycle so busy is seen before done
                     dz_q   <= 1'b1;
                     hi_q   <= a;
                     lo_q   <= {WIDTH{1'b1}};
                     opnd_q <= {WIDTH{1'b0}};
                  end else if (op) begin
                     dz_q   <= 1'b0;
                     hi_q   <= {WIDTH{1'b0}};
                     lo_q   <= mag_a_d;
                     opnd_q <= mag_b_d;
                  end else begin
                     dz_q   <= 1'b0;
                     hi_q   <= {WIDTH{1'b0}};
                     lo_q   <= mag_b_d;
                     opnd_q <= mag_a_d;
                  end
               end else begin
                  state_q <= S_IDLE;
               end
            end
            S_RUN: begin
               if (dz_q) begin
                  res_hi_q <= hi_q;
                  res_lo_q <= lo_q;
                  flags_q  <= 3'b010;
                  busy_q   <= 1'b0;
                  done_q   <= 1'b1;
                  cnt_q    <= {CW{1'b0}};
                  state_q  <= S_DONE;
               end else begin
                  hi_q  <= hi_step_d;
                  lo_q  <= lo_step_d;
                  cnt_q <= cnt_q - CW'(1);
                  if (cnt_q == CW'(1)) begin
`ifdef MDU_SIGNED_EN
                     state_q <= S_SIGN;
`else
                     res_hi_q <= fin_hi_d;
                     res_lo_q <= fin_lo_d;
                     flags_q  <= {fin_ov_d, 1'b0, fin_zf_d};
                     busy_q   <= 1'b0;
                     done_q   <= 1'b1;
                     state_q  <= S_DONE;
`endif
                  end else begin
                     state_q <= S_RUN;
                  end
               end
            end
`ifdef MDU_SIGNED_EN
            S_SIGN: begin
               res_hi_q <= fin_hi_d;
               res_lo_q <= fin_lo_d;
               flags_q  <= {fin_ov_d, 1'b0, fin_zf_d};
               busy_q   <= 1'b0;
               done_q   <= 1'b1;
               state_q  <= S_DONE;
            end
`endif
            default: begin
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign result_lo = res_lo_q;
   assign result_hi = res_hi_q;
   assign flags     = flags_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// -----------------------------------------------------------------------------
// tb_mul_div_unit
// Table-driven directed bench for mul_div_unit at WIDTH = 8, plus hand-written
// sequences for ignored mid-run start, start in the done cycle and
// asynchronous reset in the middle of an operation.
// -----------------------------------------------------------------------------
module tb_mul_div_unit;

   localparam int W = 8;
`ifdef MDU_SIGNED_EN
   localparam int LAT = W + 1;
`else
   localparam int LAT = W;
`endif

   logic         clk;
   logic         reset;
   logic         start;
   logic         op;
   logic         sop;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         busy;
   logic         done;
   logic [W-1:0] result_lo;
   logic [W-1:0] result_hi;
   logic [2:0]   flags;

   int checks;
   int failures;

   mul_div_unit #(.WIDTH(W)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .op        (op),
`ifdef MDU_SIGNED_EN
      .signed_op (sop),
`endif
      .a         (a),
      .b         (b),
      .busy      (busy),
      .done      (done),
      .result_lo (result_lo),
      .result_hi (result_hi),
      .flags     (flags)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic         op;
      logic         sg;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] lo;
      logic [W-1:0] hi;
      logic [2:0]   fl;
      int           lat;
   } vec_t;

   vec_t vq[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   // Drive a request at the falling edge; returns #1 after the accepting edge
   task automatic launch(input logic o, input logic s, input logic [W-1:0] x, input logic [W-1:0] y);
      @(negedge clk);
      start = 1'b1;
      op    = o;
      sop   = s;
      a     = x;
      b     = y;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   // Count edges until done is seen; -1 on timeout. busy_bad set if busy
   // dropped before done.
   task automatic wait_done(output int n, output logic busy_bad);
      n = -1;
      busy_bad = 1'b0;
      for (int i = 1; i <= 200; i++) begin
         @(posedge clk);
         #1;
         if (done) begin
            n = i;
            break;
         end else if (!busy) begin
            busy_bad = 1'b1;
         end else begin
            busy_bad = busy_bad;
         end
      end
   endtask

   initial begin
      int   n;
      logic bb;
      int   extra;

      checks   = 0;
      failures = 0;
      start    = 1'b0;
      op       = 1'b0;
      sop      = 1'b0;
      a        = '0;
      b        = '0;
      reset    = 1'b1;

      //               op    sg    a      b      lo     hi     flags   lat
      vq.push_back('{1'b0, 1'b0, 8'd13,  8'd11,  8'h8F, 8'h00, 3'b000, LAT});
      vq.push_back('{1'b0, 1'b0, 8'd255, 8'd255, 8'h01, 8'hFE, 3'b100, LAT});
      vq.push_back('{1'b1, 1'b0, 8'd200, 8'd7,   8'h1C, 8'h04, 3'b000, LAT});
      vq.push_back('{1'b1, 1'b0, 8'd0,   8'd5,   8'h00, 8'h00, 3'b001, LAT});
      vq.push_back('{1'b1, 1'b0, 8'd100, 8'd0,   8'hFF, 8'h64, 3'b010, 1});
      vq.push_back('{1'b0, 1'b0, 8'd0,   8'd77,  8'h00, 8'h00, 3'b001, LAT});
      vq.push_back('{1'b0, 1'b0, 8'd16,  8'd16,  8'h00, 8'h01, 3'b100, LAT});
      vq.push_back('{1'b1, 1'b0, 8'd255, 8'd1,   8'hFF, 8'h00, 3'b000, LAT});
      vq.push_back('{1'b1, 1'b0, 8'd7,   8'd200, 8'h00, 8'h07, 3'b000, LAT});
      vq.push_back('{1'b0, 1'b0, 8'd15,  8'd17,  8'hFF, 8'h00, 3'b000, LAT});
`ifdef MDU_SIGNED_EN
      vq.push_back('{1'b0, 1'b1, 8'hFA,  8'h07,  8'hD6, 8'hFF, 3'b000, LAT});
      vq.push_back('{1'b1, 1'b1, 8'hF9,  8'h02,  8'hFD, 8'hFF, 3'b000, LAT});
      vq.push_back('{1'b1, 1'b1, 8'h80,  8'hFF,  8'h80, 8'h00, 3'b100, LAT});
`endif

      // Reset state
      #3 reset = 1'b0;
      #2;
      chk("rst_busy",  {31'd0, busy}, 32'd0);
      chk("rst_done",  {31'd0, done}, 32'd0);
      chk("rst_lo",    {24'd0, result_lo}, 32'd0);
      chk("rst_hi",    {24'd0, result_hi}, 32'd0);
      chk("rst_flags", {29'd0, flags}, 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b1;

      // Table of single operations
      foreach (vq[k]) begin
         launch(vq[k].op, vq[k].sg, vq[k].a, vq[k].b);
         chk($sformatf("v%0d_busy_accept", k), {31'd0, busy}, 32'd1);
         wait_done(n, bb);
         chk($sformatf("v%0d_latency", k), n, vq[k].lat);
         chk($sformatf("v%0d_busy_run", k), {31'd0, bb}, 32'd0);
         chk($sformatf("v%0d_busy_done", k), {31'd0, busy}, 32'd0);
         chk($sformatf("v%0d_lo", k), {24'd0, result_lo}, {24'd0, vq[k].lo});
         chk($sformatf("v%0d_hi", k), {24'd0, result_hi}, {24'd0, vq[k].hi});
         chk($sformatf("v%0d_flags", k), {29'd0, flags}, {29'd0, vq[k].fl});
         @(posedge clk);
         #1;
         chk($sformatf("v%0d_done_pulse", k), {31'd0, done}, 32'd0);
         chk($sformatf("v%0d_hold_lo", k), {24'd0, result_lo}, {24'd0, vq[k].lo});
      end

      // Second start mid-RUN is ignored and not queued
      launch(1'b0, 1'b0, 8'd13, 8'd11);
      repeat (3) @(posedge clk);
      @(negedge clk);
      start = 1'b1;
      op    = 1'b1;
      a     = 8'd200;
      b     = 8'd7;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_done(n, bb);
      chk("mid_latency", n, LAT - 4);
      chk("mid_lo", {24'd0, result_lo}, 32'h8F);
      chk("mid_hi", {24'd0, result_hi}, 32'h00);
      extra = 0;
      for (int i = 0; i < LAT + 3; i++) begin
         @(posedge clk);
         #1;
         if (done || busy) extra++;
      end
      chk("mid_no_queue", extra, 0);
      chk("mid_lo_hold", {24'd0, result_lo}, 32'h8F);

      // Start raised in the done cycle is accepted on the next edge
      launch(1'b1, 1'b0, 8'd200, 8'd7);
      wait_done(n, bb);
      chk("b2b_first_lat", n, LAT);
      start = 1'b1;
      op    = 1'b0;
      a     = 8'd3;
      b     = 8'd5;
      @(posedge clk);
      #1;
      start = 1'b0;
      chk("b2b_busy", {31'd0, busy}, 32'd1);
      chk("b2b_mid_lo", {24'd0, result_lo}, 32'h1C);
      wait_done(n, bb);
      chk("b2b_latency", n, LAT);
      chk("b2b_lo", {24'd0, result_lo}, 32'h0F);

      // Asynchronous reset in the middle of RUN
      launch(1'b0, 1'b0, 8'd255, 8'd255);
      repeat (4) @(posedge clk);
      #1;
      chk("ar_busy_before", {31'd0, busy}, 32'd1);
      reset = 1'b0;
      #1;
      chk("ar_busy",  {31'd0, busy}, 32'd0);
      chk("ar_done",  {31'd0, done}, 32'd0);
      chk("ar_lo",    {24'd0, result_lo}, 32'd0);
      chk("ar_hi",    {24'd0, result_hi}, 32'd0);
      chk("ar_flags", {29'd0, flags}, 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      launch(1'b0, 1'b0, 8'd3, 8'd3);
      wait_done(n, bb);
      chk("ar_latency", n, LAT);
      chk("ar_lo_after", {24'd0, result_lo}, 32'h09);
      chk("ar_hi_after", {24'd0, result_hi}, 32'h00);
      chk("ar_flags_after", {29'd0, flags}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
